// File: rtl/car_drive_ctrl.sv
// Driver-input front end: synchronises/debounces raw controls, runs the power/drive FSM and
// drives turn requests plus a blink tick. Define AUTO_POWER_OFF_EN to add the idle power-off timer.
module car_drive_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES   = 4,
   parameter int unsigned POWER_HOLD_CYCLES = 10,
   parameter int unsigned BLINK_PERIOD      = 8,
   parameter int unsigned IDLE_TIMEOUT      = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       power_on,
   input  logic       power_off,
   input  logic       throttle,
   input  logic       clutch,
   input  logic       brake,
   input  logic       turn_left_sw,
   input  logic       turn_right_sw,
   output logic [1:0] state,
   output logic       turn_left,
   output logic       turn_right,
   output logic       blink_tick
);

   localparam int unsigned NumIn  = 7;
   localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned HoldW  = $clog2(POWER_HOLD_CYCLES + 1);
   localparam int unsigned BlinkW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
   localparam logic [DbW-1:0]    DbMax    = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldW-1:0]  HoldMax  = HoldW'(POWER_HOLD_CYCLES);
   localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_PERIOD - 1);

   if (DEBOUNCE_CYCLES == 0 || POWER_HOLD_CYCLES == 0 || BLINK_PERIOD < 2 || IDLE_TIMEOUT == 0)
   begin : gen_param_check
      $error("car_drive_ctrl: invalid parameter value");
   end

   typedef enum logic [1:0] {
      StOff         = 2'b00,
      StNotStarting = 2'b01,
      StStarting    = 2'b11,
      StMoving      = 2'b10
   } state_e;

   state_e state_q, state_d;

   logic [NumIn-1:0] raw, sync1_q, sync2_q, db_q, db_d;
   logic [DbW-1:0]   db_cnt_q [NumIn];
   logic [DbW-1:0]   db_cnt_d [NumIn];

   logic             pwr_on_db, pwr_off_db, thr_db, clu_db, brk_db, left_db, right_db;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             armed_q, armed_d;
   logic             active;
   logic [1:0]       turn_q, turn_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_q, blink_d, blink_clr;

   assign raw = {turn_right_sw, turn_left_sw, brake, clutch, throttle, power_off, power_on};
   assign {right_db, left_db, brk_db, clu_db, thr_db, pwr_off_db, pwr_on_db} = db_q;

   // Level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < NumIn; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == DbMax) db_d[i] = sync2_q[i];
            else                      db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   // A power press only counts once power_on has been seen released, so a stuck button never re-arms.
   always_comb begin
      armed_d = armed_q;
      if (!pwr_on_db)            armed_d = 1'b1;
      else if (state_q != StOff) armed_d = 1'b0;
      hold_d = '0;
      if (pwr_on_db && armed_q && state_q == StOff) begin
         hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
      end
   end

`ifdef AUTO_POWER_OFF_EN
   localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_TIMEOUT);
   logic [IdleW-1:0] idle_q, idle_d;

   always_comb begin
      idle_d = '0;
      if (state_q == StNotStarting && !(thr_db | clu_db | brk_db | left_db | right_db)) begin
         idle_d = (idle_q == IdleMax) ? idle_q : idle_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idle_q <= '0;
      else        idle_q <= idle_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StOff;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (pwr_off_db) begin
         state_d = StOff;
      end else begin
         unique case (state_q)
            StOff: if (hold_q == HoldMax) state_d = StNotStarting;
            StNotStarting: begin
               if (thr_db && !clu_db)                 state_d = StOff;
               else if (thr_db && clu_db && !brk_db)  state_d = StStarting;
`ifdef AUTO_POWER_OFF_EN
               else if (idle_q == IdleMax)            state_d = StOff;
`endif
            end
            StStarting: begin
               if (brk_db)                  state_d = StNotStarting;
               else if (thr_db && !clu_db)  state_d = StMoving;
            end
            StMoving: begin
               if (brk_db)                  state_d = StNotStarting;
               else if (clu_db || !thr_db)  state_d = StStarting;
            end
            default: state_d = StOff;
         endcase
      end
   end

   always_comb begin
      state      = state_q;
      turn_left  = turn_q[1];
      turn_right = turn_q[0];
      blink_tick = blink_q;
   end

   // Blink phase restarts whenever the request changes so the first pulse lands a full period later.
   always_comb begin
      active      = (state_q == StStarting) || (state_q == StMoving);
      turn_d      = active ? {left_db & ~right_db, right_db & ~left_db} : 2'b00;
      blink_clr   = !active || (turn_d != turn_q);
      blink_d     = !blink_clr && (blink_cnt_q == BlinkMax);
      blink_cnt_d = (blink_clr || blink_cnt_q == BlinkMax) ? '0 : blink_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_q        <= '0;
         db_cnt_q    <= '{default: '0};
         hold_q      <= '0;
         armed_q     <= 1'b0;
         turn_q      <= 2'b00;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         sync1_q     <= raw;
         sync2_q     <= sync1_q;
         db_q        <= db_d;
         db_cnt_q    <= db_cnt_d;
         hold_q      <= hold_d;
         armed_q     <= armed_d;
         turn_q      <= turn_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

endmodule

// File: tb/tb_car_drive_ctrl.sv
// Directed self-checking bench for car_drive_ctrl with default parameters (4/10/8/20).
module tb_car_drive_ctrl;

   logic       clk, rst_n;
   logic       power_on, power_off, throttle, clutch, brake, turn_left_sw, turn_right_sw;
   logic [1:0] state;
   logic       turn_left, turn_right, blink_tick;
   int         checks   = 0;
   int         failures = 0;

   car_drive_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .power_on     (power_on),
      .power_off    (power_off),
      .throttle     (throttle),
      .clutch       (clutch),
      .brake        (brake),
      .turn_left_sw (turn_left_sw),
      .turn_right_sw(turn_right_sw),
      .state        (state),
      .turn_left    (turn_left),
      .turn_right   (turn_right),
      .blink_tick   (blink_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_inputs();
      power_on = 0; power_off = 0; throttle = 0; clutch = 0; brake = 0;
      turn_left_sw = 0; turn_right_sw = 0;
      step(10);
   endtask

   // Debounced rise after 6 edges, hold counter reaches 10 after 16, state moves on edge 17.
   task automatic power_up();
      power_on = 1;
      step(17);
      power_on = 0;
   endtask

   task automatic go_moving();
      clutch = 1; throttle = 1;
      step(8);
      clutch = 0;
      step(8);
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state: got %b want 00", state); end
      checks++; if (turn_left !== 1'b0) begin failures++; $display("FAIL reset_tl: got %b want 0", turn_left); end
      checks++; if (turn_right !== 1'b0) begin failures++; $display("FAIL reset_tr: got %b want 0", turn_right); end
      checks++; if (blink_tick !== 1'b0) begin failures++; $display("FAIL reset_blink: got %b want 0", blink_tick); end
      rst_n = 1;
      step(20);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL post_reset_idle: got %b want 00", state); end
   endtask

   task automatic test_power_hold();
      power_on = 1;
      step(9);
      power_on = 0;
      step(30);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL short_press: got %b want 00", state); end
      power_on = 1;
      step(16);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL hold_early: got %b want 00", state); end
      step(1);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL hold_done: got %b want 01", state); end
      power_on = 0;
      power_off = 1;
      step(8);
      clear_inputs();
   endtask

   task automatic test_drive_seq();
      power_up();
      clutch = 1;
      step(8);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL clutch_only: got %b want 01", state); end
      throttle = 1;
      step(6);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL start_early: got %b want 01", state); end
      step(1);
      checks++; if (state !== 2'b11) begin failures++; $display("FAIL starting: got %b want 11", state); end
      clutch = 0;
      step(6);
      checks++; if (state !== 2'b11) begin failures++; $display("FAIL move_early: got %b want 11", state); end
      step(1);
      checks++; if (state !== 2'b10) begin failures++; $display("FAIL moving: got %b want 10", state); end
      brake = 1;
      step(6);
      checks++; if (state !== 2'b10) begin failures++; $display("FAIL brake_early: got %b want 10", state); end
      step(1);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL brake: got %b want 01", state); end
      // Throttle still held with clutch released: stalls out on the next cycle.
      step(1);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL stall_after_brake: got %b want 00", state); end
      clear_inputs();
   endtask

   task automatic test_stall();
      power_up();
      throttle = 1;
      step(6);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL stall_early: got %b want 01", state); end
      step(1);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL stall: got %b want 00", state); end
      clear_inputs();
   endtask

   task automatic test_stuck_power_on();
      power_on = 1;
      step(17);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL stuck_up: got %b want 01", state); end
      throttle = 1;
      step(40);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL stuck_no_rearm: got %b want 00", state); end
      clear_inputs();
      power_up();
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL rearm: got %b want 01", state); end
      power_off = 1;
      step(8);
      clear_inputs();
   endtask

   task automatic test_turn_blink_kill();
      power_up();
      go_moving();
      checks++; if (state !== 2'b10) begin failures++; $display("FAIL tb_moving: got %b want 10", state); end
      turn_left_sw = 1;
      step(6);
      checks++; if (turn_left !== 1'b0) begin failures++; $display("FAIL tl_early: got %b want 0", turn_left); end
      step(1);
      checks++; if (turn_left !== 1'b1) begin failures++; $display("FAIL tl_rise: got %b want 1", turn_left); end
      checks++; if (turn_right !== 1'b0) begin failures++; $display("FAIL tr_idle: got %b want 0", turn_right); end
      for (int k = 1; k <= 16; k++) begin
         step(1);
         checks++;
         if (blink_tick !== ((k == 8) || (k == 16))) begin
            failures++;
            $display("FAIL blink_left k=%0d: got %b want %b", k, blink_tick, (k == 8) || (k == 16));
         end
      end
      turn_right_sw = 1;
      step(6);
      checks++; if (turn_left !== 1'b1) begin failures++; $display("FAIL both_early: got %b want 1", turn_left); end
      step(1);
      checks++; if ({turn_left, turn_right} !== 2'b00) begin failures++; $display("FAIL both_on: got %b want 00", {turn_left, turn_right}); end
      for (int k = 1; k <= 8; k++) begin
         step(1);
         checks++;
         if (blink_tick !== (k == 8)) begin
            failures++;
            $display("FAIL blink_restart k=%0d: got %b want %b", k, blink_tick, k == 8);
         end
      end
      turn_right_sw = 0;
      step(7);
      checks++; if (turn_left !== 1'b1) begin failures++; $display("FAIL tl_again: got %b want 1", turn_left); end
      power_off = 1;
      step(6);
      checks++; if (state !== 2'b10) begin failures++; $display("FAIL kill_early: got %b want 10", state); end
      step(1);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL kill: got %b want 00", state); end
      checks++; if (turn_left !== 1'b1) begin failures++; $display("FAIL kill_tl_lag: got %b want 1", turn_left); end
      step(1);
      checks++; if (turn_left !== 1'b0) begin failures++; $display("FAIL kill_tl_off: got %b want 0", turn_left); end
      clear_inputs();
   endtask

   task automatic test_idle();
      power_up();
`ifdef AUTO_POWER_OFF_EN
      step(20);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL idle_early: got %b want 01", state); end
      step(1);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL idle_off: got %b want 00", state); end
      clear_inputs();
      power_up();
      step(10);
      brake = 1;
      step(5);
      brake = 0;
      step(26);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL idle_brake_early: got %b want 01", state); end
      step(1);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL idle_brake_off: got %b want 00", state); end
`else
      step(60);
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL ns_persist: got %b want 01", state); end
`endif
      power_off = 1;
      step(8);
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      power_up();
      go_moving();
      turn_right_sw = 1;
      step(7);
      checks++; if (turn_right !== 1'b1) begin failures++; $display("FAIL mid_tr: got %b want 1", turn_right); end
      #2 rst_n = 0;
      #1;
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL async_state: got %b want 00", state); end
      checks++; if ({turn_left, turn_right, blink_tick} !== 3'b000) begin failures++; $display("FAIL async_outs: got %b want 000", {turn_left, turn_right, blink_tick}); end
      @(negedge clk);
      rst_n = 1;
      clear_inputs();
      step(20);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL after_reset: got %b want 00", state); end
      power_up();
      checks++; if (state !== 2'b01) begin failures++; $display("FAIL reset_repower: got %b want 01", state); end
   endtask

   initial begin
      test_reset();
      test_power_hold();
      test_drive_seq();
      test_stall();
      test_stuck_power_on();
      test_turn_blink_kill();
      test_idle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/car_drive_ctrl.md
Name: car_drive_ctrl

Overview:
- Driver-input front end for the car simulation; the producing end of the lighting interface.
- Debounces the raw driver controls, runs the car power/drive state machine and emits the 2-bit `state` code.
- Also emits registered turn requests and a blink tick; the turn-light block consumes all three.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles (after the synchroniser) before a debounced level updates.
- POWER_HOLD_CYCLES, 10, cycles `power_on` must stay debounced-high to leave OFF.
- BLINK_PERIOD, 8, cycles between `blink_tick` pulses.
- IDLE_TIMEOUT, 20, idle cycles in NOT_STARTING before auto power-off; used only with AUTO_POWER_OFF_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- power_on  input  1  raw power button, asynchronous
- power_off  input  1  raw kill button, asynchronous
- throttle  input  1  raw throttle switch
- clutch  input  1  raw clutch switch
- brake  input  1  raw brake switch
- turn_left_sw  input  1  raw left indicator switch
- turn_right_sw  input  1  raw right indicator switch
- state  output  2  OFF=2'b00, NOT_STARTING=2'b01, STARTING=2'b11, MOVING=2'b10
- turn_left  output  1  registered left turn request
- turn_right  output  1  registered right turn request
- blink_tick  output  1  one-cycle blink enable pulse

Behaviour:
- Reset is asynchronous, active low, and fixed by the interface.
  - While `rst_n` is low: `state` = OFF, `turn_left` = 0, `turn_right` = 0, `blink_tick` = 0; all counters and synchronisers clear.
- Input conditioning:
  - Each raw input passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level takes the synchronised value after DEBOUNCE_CYCLES consecutive equal samples.
  - Total input-to-debounced latency is 2 + DEBOUNCE_CYCLES cycles; the state update occurs 1 cycle later.
- Hold counter:
  - Counts while debounced `power_on` = 1 and `state` = OFF; it saturates at POWER_HOLD_CYCLES.
  - It clears when `power_on` drops or when `state` leaves OFF.
- Transition priority, evaluated each cycle on debounced levels (P = power_off, T = throttle, C = clutch, B = brake):
  1. P = 1: any state goes to OFF.
  2. OFF: goes to NOT_STARTING on the cycle the hold counter reaches POWER_HOLD_CYCLES. A press shorter than that does nothing.
  3. NOT_STARTING:
     - T & ~C goes to OFF (stall).
     - T & C & ~B goes to STARTING.
     - Otherwise stay.
  4. STARTING:
     - B goes to NOT_STARTING.
     - T & ~C goes to MOVING.
     - Otherwise stay.
  5. MOVING:
     - B goes to NOT_STARTING.
     - C | ~T goes to STARTING.
     - Otherwise stay.
- After power-off, `power_on` must be released and re-held for a full POWER_HOLD_CYCLES before restarting. A stuck `power_on` never re-arms.
- Turn requests, registered each cycle:
  - In OFF or NOT_STARTING: both outputs are 0.
  - Otherwise: {`turn_left`, `turn_right`} = {L & ~R, R & ~L} using debounced switch levels L and R.
  - Both switches on gives both outputs 0.
- Blink tick:
  - A counter runs 0..BLINK_PERIOD-1 and wraps.
  - `blink_tick` = 1 for exactly one cycle when the counter equals BLINK_PERIOD-1.
  - The counter clears to 0 on any change of {`turn_left`, `turn_right`} and whenever `state` is OFF or NOT_STARTING. The first pulse after a new request therefore arrives exactly BLINK_PERIOD cycles later.
- All outputs are registered; there is no combinational path from input to output.

Optional Feature:
- Macro: AUTO_POWER_OFF_EN.
- Defined:
  - An idle counter increments each cycle while `state` = NOT_STARTING and debounced T, C, B, L and R are all 0.
  - The counter clears on any of those inputs going to 1 or on leaving NOT_STARTING.
  - When it reaches IDLE_TIMEOUT, the next state is OFF. `power_off` still has priority.
- Undefined: there is no idle counter, and NOT_STARTING persists indefinitely.

Test Plan:
- Power-on hold (DEBOUNCE_CYCLES=4, POWER_HOLD_CYCLES=10):
  - Hold `power_on` for 9 debounced cycles, then release → `state` stays 2'b00.
  - Hold for ≥10 debounced cycles → `state` = 2'b01 exactly 1 cycle after the counter reaches 10.
- Drive sequence:
  - From NOT_STARTING, set C=1 then T=1 → 2'b11.
  - Release C → 2'b10.
  - Set B=1 → 2'b01.
  - Each step's latency from the raw edge to the `state` change is 2+4+1 = 7 cycles.
- Stall and kill:
  - In NOT_STARTING, set T=1 with C=0 → 2'b00.
  - In MOVING, pulse `power_off` ≥7 cycles → 2'b00, with `turn_left`/`turn_right` = 0 on the next cycle.
- Turn and blink (BLINK_PERIOD=8), in MOVING:
  - `turn_left_sw`=1 → `turn_left`=1 and `blink_tick` pulses every 8 cycles, first pulse 8 cycles after `turn_left` rises.
  - Add `turn_right_sw`=1 → both outputs 0 and the counter restarts.
- Reset mid-operation: assert `rst_n`=0 asynchronously in MOVING with `turn_right` active → all outputs 0 immediately, without waiting for a clock edge. After release, `state` = 2'b00 until a new power hold completes.
- AUTO_POWER_OFF_EN (IDLE_TIMEOUT=20):
  - Idle in NOT_STARTING for 20 cycles → 2'b00.
  - Toggle brake at cycle 15 → the counter restarts, and OFF comes 20 cycles after the debounced brake release.
